conv_mac_accumulator: RTL and testbench

- Four-lane multiply-accumulate stage directly downstream of the conv address generator and its weight/input buffers.
- Consumes the generator's clear/valid/write_n/out_n_address strobes plus the buffer read data x_n/w_n.
- Accumulates one KxKxC window per lane, then applies shift, optional ReLU and saturation.
- Issues one write per lane into the output buffers.

---
 rtl/conv_mac_accumulator_pkg.sv | 38 +++
 rtl/conv_mac_accumulator_mac_lane.sv | 57 +++++
 rtl/conv_mac_accumulator.sv | 228 ++++++++++++++++++++++
 tb/tb_conv_mac_accumulator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_accumulator_pkg.sv
// ==========================================================================
// conv_pkg: lane count, shared FSM states and the result finalize helper.
// Rev 1.0
// ==========================================================================
`default_nettype none

package conv_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Arithmetic shift, optional ReLU, then clamp to the signed data_width range.
  function automatic logic signed [63:0] finalize(
    input logic signed [63:0] acc,
    input int                 frac_bits,
    input int                 data_width,
    input bit                 relu
  );
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = acc >>> frac_bits;
    hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_width - 1));
    if (relu && (v < 64'sd0)) v = 64'sd0;
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_accumulator_mac_lane.sv
// ==========================================================================
// mac_lane: one lane's accumulator, finalize stage and output write registers.
// Rev 1.0
// ==========================================================================
`default_nettype none

module mac_lane
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int FRAC_BITS  = 0,
  parameter int RELU       = 1,
  parameter int ADDR_BITS  = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         acc_clear,
  input  logic                         acc_en,
  input  logic                         fin_en,
  input  logic                         we_fire,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic        [ADDR_BITS-1:0]  addr,
  output logic        [DATA_WIDTH-1:0] result,
  output logic        [ADDR_BITS-1:0]  wr_address,
  output logic                         we
);

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    acc;

  assign product = x * w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      result     <= '0;
      wr_address <= '0;
      we         <= 1'b0;
    end else begin
      we <= we_fire;
      if (acc_clear) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc + ACC_WIDTH'(product);
      end
      if (fin_en) begin
        result     <= DATA_WIDTH'(finalize(64'(acc), FRAC_BITS, DATA_WIDTH, RELU != 0));
        wr_address <= addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_mac_accumulator.sv
// ==========================================================================
// conv_mac_accumulator: four-lane windowed MAC with aligned controls and writes.
// Rev 1.0
// ==========================================================================
`default_nettype none

module conv_mac_accumulator
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH                 = 8,
  parameter int ACC_WIDTH                  = 24,
  parameter int FRAC_BITS                  = 0,
  parameter int READ_LATENCY               = 1,
  parameter int MACS_PER_WINDOW            = 27,
  parameter int RELU                       = 1,
  parameter int OUTPUT_BUFFER_ADDRESS_BITS = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  valid,
  input  logic                                  write_1,
  input  logic                                  write_2,
  input  logic                                  write_3,
  input  logic                                  write_4,
  input  logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_1_address,
  input  logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_2_address,
  input  logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_3_address,
  input  logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_4_address,
  input  logic signed [DATA_WIDTH-1:0]          x_1_data,
  input  logic signed [DATA_WIDTH-1:0]          x_2_data,
  input  logic signed [DATA_WIDTH-1:0]          x_3_data,
  input  logic signed [DATA_WIDTH-1:0]          x_4_data,
  input  logic signed [DATA_WIDTH-1:0]          w_1_data,
  input  logic signed [DATA_WIDTH-1:0]          w_2_data,
  input  logic signed [DATA_WIDTH-1:0]          w_3_data,
  input  logic signed [DATA_WIDTH-1:0]          w_4_data,
  output logic [DATA_WIDTH-1:0]                 out_1_data,
  output logic [DATA_WIDTH-1:0]                 out_2_data,
  output logic [DATA_WIDTH-1:0]                 out_3_data,
  output logic [DATA_WIDTH-1:0]                 out_4_data,
  output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_1_wr_address,
  output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_2_wr_address,
  output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_3_wr_address,
  output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_4_wr_address,
  output logic                                  out_1_we,
  output logic                                  out_2_we,
  output logic                                  out_3_we,
  output logic                                  out_4_we,
  output logic                                  busy,
  output logic                                  count_error
);

  localparam int AW = OUTPUT_BUFFER_ADDRESS_BITS;
  localparam int CW = $clog2(MACS_PER_WINDOW + 1) + 1;

  logic [LANES-1:0]             write_a;
  logic [AW-1:0]                addr_a  [LANES];
  logic signed [DATA_WIDTH-1:0] x_a     [LANES];
  logic signed [DATA_WIDTH-1:0] w_a     [LANES];
  logic [DATA_WIDTH-1:0]        res_a   [LANES];
  logic [AW-1:0]                wra_a   [LANES];
  logic [LANES-1:0]             we_a;

  assign write_a   = {write_4, write_3, write_2, write_1};
  assign addr_a[0] = out_1_address;
  assign addr_a[1] = out_2_address;
  assign addr_a[2] = out_3_address;
  assign addr_a[3] = out_4_address;
  assign x_a[0]    = x_1_data;
  assign x_a[1]    = x_2_data;
  assign x_a[2]    = x_3_data;
  assign x_a[3]    = x_4_data;
  assign w_a[0]    = w_1_data;
  assign w_a[1]    = w_2_data;
  assign w_a[2]    = w_3_data;
  assign w_a[3]    = w_4_data;

  assign out_1_data       = res_a[0];
  assign out_2_data       = res_a[1];
  assign out_3_data       = res_a[2];
  assign out_4_data       = res_a[3];
  assign out_1_wr_address = wra_a[0];
  assign out_2_wr_address = wra_a[1];
  assign out_3_wr_address = wra_a[2];
  assign out_4_wr_address = wra_a[3];
  assign {out_4_we, out_3_we, out_2_we, out_1_we} = we_a;

  logic                    win_q;
  logic                    issue;
  logic [READ_LATENCY-1:0] clear_dl;
  logic [READ_LATENCY-1:0] issue_dl;
  logic [READ_LATENCY-1:0] valid_dl;
  logic [LANES-1:0]        write_dl [READ_LATENCY];
  logic [AW-1:0]           addr_dl  [READ_LATENCY][LANES];
  logic                    clear_d;
  logic                    issue_d;
  logic                    valid_d;
  logic [LANES-1:0]        write_d;

  assign issue   = win_q & ~valid;
  assign clear_d = clear_dl[READ_LATENCY-1];
  assign issue_d = issue_dl[READ_LATENCY-1];
  assign valid_d = valid_dl[READ_LATENCY-1];
  assign write_d = write_dl[READ_LATENCY-1];

  // Address stage 0 only loads on raw valid, so the tail of the line holds
  // the window's address exactly when valid_d arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q    <= 1'b0;
      clear_dl <= '0;
      issue_dl <= '0;
      valid_dl <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        write_dl[k] <= '0;
        for (int i = 0; i < LANES; i++) addr_dl[k][i] <= '0;
      end
    end else begin
      if (clear)      win_q <= 1'b1;
      else if (valid) win_q <= 1'b0;
      clear_dl[0] <= clear;
      issue_dl[0] <= issue;
      valid_dl[0] <= valid;
      write_dl[0] <= write_a;
      for (int i = 0; i < LANES; i++) begin
        if (valid) addr_dl[0][i] <= addr_a[i];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        clear_dl[k] <= clear_dl[k-1];
        issue_dl[k] <= issue_dl[k-1];
        valid_dl[k] <= valid_dl[k-1];
        write_dl[k] <= write_dl[k-1];
        for (int i = 0; i < LANES; i++) addr_dl[k][i] <= addr_dl[k-1][i];
      end
    end
  end

  state_t  state;
  state_t  state_nx;
  logic    acc_clear;
  logic    acc_en;
  logic    fin_en;
  logic    we_fire;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    fin_en    = 1'b0;
    we_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (clear_d) begin
          acc_clear = 1'b1;
          state_nx  = ACCUM;
        end
      end
      ACCUM: begin
        if (clear_d) begin
          acc_clear = 1'b1;
        end else if (valid_d) begin
          fin_en   = 1'b1;
          state_nx = HOLD;
        end else if (issue_d) begin
          acc_en = 1'b1;
        end
      end
      HOLD: begin
        if (clear_d) begin
          acc_clear = 1'b1;
          state_nx  = ACCUM;
        end else if (|write_d) begin
          we_fire  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counter saturates so an over-long window cannot wrap back onto the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      count_error <= 1'b0;
    end else begin
      if (acc_clear)                        count <= '0;
      else if (acc_en && (count != '1))     count <= count + CW'(1);
      if ((state == ACCUM) && clear_d)      count_error <= 1'b1;
      if (fin_en && (count != CW'(MACS_PER_WINDOW))) count_error <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .RELU       (RELU),
      .ADDR_BITS  (AW)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .acc_clear  (acc_clear),
      .acc_en     (acc_en),
      .fin_en     (fin_en),
      .we_fire    (we_fire & write_d[i]),
      .x          (x_a[i]),
      .w          (w_a[i]),
      .addr       (addr_dl[READ_LATENCY-1][i]),
      .result     (res_a[i]),
      .wr_address (wra_a[i]),
      .we         (we_a[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_accumulator.sv
// ==========================================================================
// tb_conv_mac_accumulator: scoreboard bench, RELU=1 and RELU=0 DUTs in parallel.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_conv_mac_accumulator;

  localparam int RL   = 2;
  localparam int MACS = 27;
  localparam int FRAC = 0;

  logic                clk = 1'b0;
  logic                rst;
  logic                clear;
  logic                valid;
  logic [3:0]          wr;
  logic [6:0]          oaddr [4];
  logic signed [7:0]   x [4];
  logic signed [7:0]   w [4];
  logic [7:0]          d_r [4];
  logic [7:0]          d_l [4];
  logic [6:0]          a_r [4];
  logic [6:0]          a_l [4];
  logic [3:0]          we_r;
  logic [3:0]          we_l;
  logic                busy_r, busy_l, ce_r, ce_l;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit err_model;

  logic signed [7:0] nx [4];
  logic signed [7:0] nw [4];
  logic signed [7:0] px [RL+1][4];
  logic signed [7:0] pw [RL+1][4];

  typedef struct packed {
    logic [3:0][31:0] sum;
    logic [3:0][6:0]  addr;
    logic [3:0]       mask;
    logic [31:0]      at;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mac_accumulator #(.READ_LATENCY(RL), .RELU(1), .FRAC_BITS(FRAC)) dut_relu (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid),
    .write_1(wr[0]), .write_2(wr[1]), .write_3(wr[2]), .write_4(wr[3]),
    .out_1_address(oaddr[0]), .out_2_address(oaddr[1]), .out_3_address(oaddr[2]), .out_4_address(oaddr[3]),
    .x_1_data(x[0]), .x_2_data(x[1]), .x_3_data(x[2]), .x_4_data(x[3]),
    .w_1_data(w[0]), .w_2_data(w[1]), .w_3_data(w[2]), .w_4_data(w[3]),
    .out_1_data(d_r[0]), .out_2_data(d_r[1]), .out_3_data(d_r[2]), .out_4_data(d_r[3]),
    .out_1_wr_address(a_r[0]), .out_2_wr_address(a_r[1]), .out_3_wr_address(a_r[2]), .out_4_wr_address(a_r[3]),
    .out_1_we(we_r[0]), .out_2_we(we_r[1]), .out_3_we(we_r[2]), .out_4_we(we_r[3]),
    .busy(busy_r), .count_error(ce_r)
  );

  conv_mac_accumulator #(.READ_LATENCY(RL), .RELU(0), .FRAC_BITS(FRAC)) dut_lin (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid),
    .write_1(wr[0]), .write_2(wr[1]), .write_3(wr[2]), .write_4(wr[3]),
    .out_1_address(oaddr[0]), .out_2_address(oaddr[1]), .out_3_address(oaddr[2]), .out_4_address(oaddr[3]),
    .x_1_data(x[0]), .x_2_data(x[1]), .x_3_data(x[2]), .x_4_data(x[3]),
    .w_1_data(w[0]), .w_2_data(w[1]), .w_3_data(w[2]), .w_4_data(w[3]),
    .out_1_data(d_l[0]), .out_2_data(d_l[1]), .out_3_data(d_l[2]), .out_4_data(d_l[3]),
    .out_1_wr_address(a_l[0]), .out_2_wr_address(a_l[1]), .out_3_wr_address(a_l[2]), .out_4_wr_address(a_l[3]),
    .out_1_we(we_l[0]), .out_2_we(we_l[1]), .out_3_we(we_l[2]), .out_4_we(we_l[3]),
    .busy(busy_l), .count_error(ce_l)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: 24-bit two's-complement wrap of the exact sum.
  function automatic int wrap24(input longint s);
    longint m;
    m = s & 64'hFF_FFFF;
    if (m >= 64'h80_0000) m = m - 64'h100_0000;
    return int'(m);
  endfunction

  function automatic int fin_ref(input int acc, input bit relu);
    int v;
    v = acc >>> FRAC;
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  // Models the buffer: data requested in cycle t is presented in cycle t+RL.
  task automatic cycle();
    for (int k = RL; k > 0; k--) begin
      for (int i = 0; i < 4; i++) begin
        px[k][i] = px[k-1][i];
        pw[k][i] = pw[k-1][i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      px[0][i] = nx[i];
      pw[0][i] = nw[i];
      x[i] = px[RL][i];
      w[i] = pw[RL][i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    for (int i = 0; i < 4; i++) begin
      nx[i] = 8'($urandom);
      nw[i] = 8'($urandom);
    end
  endtask

  task automatic zero();
    for (int i = 0; i < 4; i++) begin
      nx[i] = '0;
      nw[i] = '0;
    end
  endtask

  task automatic window(input int mode, input int n_issue, input int mid_at,
                        input logic [3:0] wm, input logic [3:0][6:0] ad, input int hold);
    longint s [4];
    int     cnt;
    exp_t   e;
    for (int i = 0; i < 4; i++) s[i] = 0;
    cnt = 0;
    clear = 1'b1; zero(); cycle(); clear = 1'b0;
    for (int j = 0; j < n_issue; j++) begin
      if (j == mid_at) begin
        clear = 1'b1; zero(); cycle(); clear = 1'b0;
        for (int i = 0; i < 4; i++) s[i] = 0;
        cnt = 0;
        err_model = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        case (mode)
          0:       begin nx[i] = 8'sd1;    nw[i] = 8'sd2;   end
          1:       begin nx[i] = 8'sd10;   nw[i] = 8'sd10;  end
          2:       begin nx[i] = -8'sd128; nw[i] = 8'sd127; end
          default: begin nx[i] = 8'($urandom); nw[i] = 8'($urandom); end
        endcase
        s[i] += longint'(nx[i]) * longint'(nw[i]);
      end
      cnt++;
      cycle();
    end
    valid = 1'b1;
    for (int i = 0; i < 4; i++) oaddr[i] = ad[i];
    junk(); cycle();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) oaddr[i] = ~ad[i];
    if (cnt != MACS) err_model = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.sum[i]  = 32'(wrap24(s[i]));
      e.addr[i] = ad[i];
    end
    e.mask = wm;
    e.at   = 32'(cyc + RL + 1);
    q.push_back(e);
    wr = wm; junk(); cycle();
    for (int h = 1; h < hold; h++) begin junk(); cycle(); end
    wr = '0;
    repeat (RL + 3) begin junk(); cycle(); end
    check("busy_relu", busy_r, 0);
    check("busy_lin", busy_l, 0);
    check("count_error_relu", ce_r, err_model);
    check("count_error_lin", ce_l, err_model);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, {we_r, we_l}, 0);
    check({tag, "_busy"}, {busy_r, busy_l}, 0);
    check({tag, "_count_error"}, {ce_r, ce_l}, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), {d_r[i], d_l[i]}, 0);
      check($sformatf("%s_addr[%0d]", tag, i), {a_r[i], a_l[i]}, 0);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding window.
  initial forever begin
    @(negedge clk);
    if (!rst && (we_r != 4'd0 || we_l != 4'd0)) begin
      if (q.size() == 0) begin
        check("unexpected_we", {we_r, we_l}, 0);
      end else begin : pop
        exp_t e;
        e = q.pop_front();
        check("we_cycle", cyc, e.at);
        check("we_mask_relu", we_r, e.mask);
        check("we_mask_lin", we_l, e.mask);
        for (int i = 0; i < 4; i++) begin
          if (e.mask[i]) begin
            check($sformatf("data_relu[%0d]", i), $signed(d_r[i]), fin_ref($signed(e.sum[i]), 1'b1));
            check($sformatf("data_lin[%0d]", i), $signed(d_l[i]), fin_ref($signed(e.sum[i]), 1'b0));
            check($sformatf("addr_relu[%0d]", i), a_r[i], e.addr[i]);
            check($sformatf("addr_lin[%0d]", i), a_l[i], e.addr[i]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0][6:0] ad;
    rst = 1'b1; clear = 1'b0; valid = 1'b0; wr = '0; err_model = 1'b0;
    for (int i = 0; i < 4; i++) begin
      oaddr[i] = '0; x[i] = '0; w[i] = '0; nx[i] = '0; nw[i] = '0;
      for (int k = 0; k <= RL; k++) begin px[k][i] = '0; pw[k][i] = '0; end
    end
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) cycle();

    window(0, MACS, -1, 4'hF, {7'd80, 7'd55, 7'd30, 7'd5}, 3);
    window(1, MACS, -1, 4'hF, {7'd1, 7'd2, 7'd3, 7'd4}, 2);
    window(2, MACS, -1, 4'hF, {7'd9, 7'd10, 7'd11, 7'd12}, 1);
    window(3, MACS, -1, 4'b0011, {7'd100, 7'd101, 7'd102, 7'd103}, 2);
    window(0, MACS, -1, 4'hF, {7'd20, 7'd21, 7'd22, 7'd23}, 20);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) ad[i] = 7'($urandom);
      window(3, MACS, -1, 4'($urandom_range(1, 15)), ad, $urandom_range(1, 5));
    end

    window(3, MACS - 1, -1, 4'hF, {7'd40, 7'd41, 7'd42, 7'd43}, 2);
    window(0, MACS, -1, 4'hF, {7'd44, 7'd45, 7'd46, 7'd47}, 2);

    clear = 1'b1; zero(); cycle(); clear = 1'b0;
    for (int j = 0; j < 10; j++) begin junk(); cycle(); end
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    err_model = 1'b0;
    repeat (2) begin junk(); cycle(); end

    window(3, MACS, -1, 4'hF, {7'd60, 7'd61, 7'd62, 7'd63}, 2);
    window(0, MACS + 10, 10, 4'hF, {7'd70, 7'd71, 7'd72, 7'd73}, 2);

    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
